sprite_scanline_renderer: RTL and testbench

Reads the sprite record words published by `game_engine` (player tank, opponent tank, and `2*MAX_BULLETS` bullets) and turns them into pixel colour for the VGA path. During each horizontal blank it scans every record once and builds a short list of sprites that cover the next scanline. During active video it compares `pixel_x` against that list and drives a registered 12-bit RGB value. It sits between `game_engine` and the VGA output stage.

---
 rtl/tankwar_pkg.sv | 42 ++++
 rtl/sprite_span_unit.sv | 48 ++++
 rtl/sprite_scanline_renderer.sv | 138 +++++++++++++
 tb/tb_sprite_scanline_renderer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tankwar_pkg.sv
// Shared definitions for the tank-war video path: sprite record layout,
// sprite classes, palette and default sprite sizes.
package tankwar_pkg;

   localparam int COORD_W        = 10;
   localparam int SIZE_W         = 8;
   localparam int REC_ACTIVE_BIT = 28;
   localparam int REC_X_LSB      = 18;
   localparam int REC_Y_LSB      = 8;

   typedef struct packed {
      logic [2:0]         rsvd_hi;
      logic               active;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [7:0]         rsvd_lo;
   } sprite_rec_t;

   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_TANK,
      CLS_OPPO,
      CLS_BULLET
   } sprite_class_e;

   localparam logic [11:0] TANK_COLOR   = 12'h0F0;
   localparam logic [11:0] OPPO_COLOR   = 12'hF00;
   localparam logic [11:0] BULLET_COLOR = 12'hFF0;

   localparam int DEF_TANK_SIZE   = 16;
   localparam int DEF_BULLET_SIZE = 4;

   function automatic logic [11:0] class_color(input sprite_class_e cls);
      case (cls)
         CLS_TANK:   return TANK_COLOR;
         CLS_OPPO:   return OPPO_COLOR;
         CLS_BULLET: return BULLET_COLOR;
         default:    return 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/sprite_span_unit.sv
// One entry of the per-line hit list: stores a sprite's horizontal span and
// class, and flags when the current pixel column falls inside that span.
module sprite_span_unit
   import tankwar_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [COORD_W-1:0] i_x,
   input  logic [SIZE_W-1:0]  i_size,
   input  sprite_class_e      i_cls,
   input  logic [COORD_W-1:0] i_pixel_x,
   output logic               o_hit,
   output sprite_class_e      o_cls
);

   logic               r_valid;
   logic [COORD_W-1:0] r_x;
   logic [SIZE_W-1:0]  r_size;
   sprite_class_e      r_cls;
   logic [COORD_W:0]   w_x_end;

   // NOTE: only r_valid must be reset for correct behaviour; the payload is
   // reset as well so no X ever reaches the colour mux.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_x     <= '0;
         r_size  <= '0;
         r_cls   <= CLS_NONE;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_x     <= i_x;
         r_size  <= i_size;
         r_cls   <= i_cls;
      end
   end

   // One extra bit so a sprite near column 1023 never wraps onto column 0.
   assign w_x_end = {1'b0, r_x} + (COORD_W+1)'(r_size);
   assign o_hit   = r_valid && ({1'b0, i_pixel_x} >= {1'b0, r_x})
                            && ({1'b0, i_pixel_x} <  w_x_end);
   assign o_cls   = r_cls;

endmodule

// File: rtl/sprite_scanline_renderer.sv
// Builds a per-scanline sprite hit list during horizontal blank and turns it
// into a registered 12-bit RGB pixel stream during active video.
module sprite_scanline_renderer
   import tankwar_pkg::*;
#(
   parameter int MAX_BULLETS = 8,
   parameter int LIST_DEPTH  = 8,
   parameter int TANK_SIZE   = DEF_TANK_SIZE,
   parameter int BULLET_SIZE = DEF_BULLET_SIZE,
   parameter int V_TOTAL     = 525
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               video_on,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic               line_end,
   input  logic [31:0]        tank_ram_data,
   input  logic [31:0]        oppo_ram_data,
   input  logic [31:0]        bullet_ram_data [2*MAX_BULLETS],
   output logic [11:0]        rgb,
   output logic               scan_busy,
   output logic               overflow
);

   localparam int NREC   = 2 + 2*MAX_BULLETS;
   localparam int IDX_W  = $clog2(NREC);
   localparam int FILL_W = $clog2(LIST_DEPTH + 1);

   typedef enum logic {ST_IDLE, ST_SCAN} state_e;

   state_e             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [COORD_W-1:0] r_line_y;
   logic [FILL_W-1:0]  r_fill;
   logic               r_scan_busy;
   logic               r_overflow;
   logic [11:0]        r_rgb;

   logic [31:0]        w_recs [NREC];
   sprite_rec_t        w_rec;
   logic [SIZE_W-1:0]  w_size;
   sprite_class_e      w_cls;
   logic [COORD_W:0]   w_y_end;
   logic               w_line_hit;
   logic               w_full;
   logic               w_append;
   logic               w_unused_rec;
   logic [LIST_DEPTH-1:0] w_hit;
   sprite_class_e      w_ent_cls [LIST_DEPTH];
   logic [11:0]        w_pix_color;

   // Index order is both scan order and draw priority.
   always_comb begin
      w_recs[0] = tank_ram_data;
      w_recs[1] = oppo_ram_data;
      for (int k = 0; k < 2*MAX_BULLETS; k++) begin
         w_recs[k+2] = bullet_ram_data[k];
      end
   end

   assign w_rec  = sprite_rec_t'(w_recs[r_idx]);
   assign w_size = (r_idx < IDX_W'(2)) ? SIZE_W'(TANK_SIZE) : SIZE_W'(BULLET_SIZE);
   assign w_cls  = (r_idx == IDX_W'(0)) ? CLS_TANK :
                   (r_idx == IDX_W'(1)) ? CLS_OPPO : CLS_BULLET;
   assign w_unused_rec = ^{w_rec.rsvd_hi, w_rec.rsvd_lo};

   assign w_y_end    = {1'b0, w_rec.y} + (COORD_W+1)'(w_size);
   assign w_line_hit = w_rec.active && ({1'b0, r_line_y} >= {1'b0, w_rec.y})
                                    && ({1'b0, r_line_y} <  w_y_end);
   assign w_full     = (r_fill == FILL_W'(LIST_DEPTH));
   // A line_end during the scan restarts it, so that cycle never appends.
   assign w_append   = (r_state == ST_SCAN) && !line_end && w_line_hit && !w_full;

   for (genvar e = 0; e < LIST_DEPTH; e++) begin : g_list
      sprite_span_unit u_span (
         .clk       (clk),
         .reset     (reset),
         .i_clear   (line_end),
         .i_load    (w_append && (r_fill == FILL_W'(e))),
         .i_x       (w_rec.x),
         .i_size    (w_size),
         .i_cls     (w_cls),
         .i_pixel_x (pixel_x),
         .o_hit     (w_hit[e]),
         .o_cls     (w_ent_cls[e])
      );
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_pix_color = '0;
      for (int e = LIST_DEPTH-1; e >= 0; e--) begin
         if (w_hit[e]) w_pix_color = class_color(w_ent_cls[e]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_line_y    <= '0;
         r_fill      <= '0;
         r_scan_busy <= 1'b0;
         r_overflow  <= 1'b0;
         r_rgb       <= '0;
      end else begin
         r_rgb <= (video_on && !r_scan_busy) ? w_pix_color : 12'h000;
         if (line_end) begin
            r_state     <= ST_SCAN;
            r_scan_busy <= 1'b1;
            r_idx       <= '0;
            r_fill      <= '0;
            r_line_y    <= (pixel_y == COORD_W'(V_TOTAL-1)) ? '0 : pixel_y + COORD_W'(1);
         end else if (r_state == ST_SCAN) begin
            if (w_line_hit) begin
               if (w_full) r_overflow <= 1'b1;
               else        r_fill     <= r_fill + FILL_W'(1);
            end
            if (r_idx == IDX_W'(NREC-1)) begin
               r_state     <= ST_IDLE;
               r_scan_busy <= 1'b0;
               r_idx       <= '0;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

   assign rgb       = r_rgb;
   assign scan_busy = r_scan_busy;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Self-checking bench for sprite_scanline_renderer: directed vector tables,
// multi-cycle corner sequences and a randomized run against a line/pixel model.
module tb_sprite_scanline_renderer;

   localparam int MAX_BULLETS = 8;
   localparam int NB          = 2*MAX_BULLETS;
   localparam int NREC        = 2 + NB;
   localparam int LIST_DEPTH  = 8;

   typedef struct {
      string       name;
      int          px;
      bit          vid;
      logic [11:0] exp_rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        video_on;
   logic        line_end;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [31:0] tank;
   logic [31:0] oppo;
   logic [31:0] bullets [NB];
   logic [11:0] rgb;
   logic        scan_busy;
   logic        overflow;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   exp_ovf  = 1'b0;
   int   line_y_m = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   sprite_scanline_renderer #(
      .MAX_BULLETS (MAX_BULLETS),
      .LIST_DEPTH  (LIST_DEPTH),
      .TANK_SIZE   (16),
      .BULLET_SIZE (4),
      .V_TOTAL     (525)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .video_on        (video_on),
      .pixel_x         (pixel_x),
      .pixel_y         (pixel_y),
      .line_end        (line_end),
      .tank_ram_data   (tank),
      .oppo_ram_data   (oppo),
      .bullet_ram_data (bullets),
      .rgb             (rgb),
      .scan_busy       (scan_busy),
      .overflow        (overflow)
   );

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_rec(input bit act, input int x, input int y);
      logic [9:0] xv = 10'(x);
      logic [9:0] yv = 10'(y);
      return {3'b000, act, xv, yv, 8'h00};
   endfunction

   function automatic logic [31:0] rec_at(input int r);
      if (r == 0) return tank;
      if (r == 1) return oppo;
      return bullets[r-2];
   endfunction

   function automatic int size_of(input int r);
      return (r < 2) ? 16 : 4;
   endfunction

   function automatic logic [11:0] color_of(input int r);
      if (r == 0) return 12'h0F0;
      if (r == 1) return 12'hF00;
      return 12'hFF0;
   endfunction

   function automatic bool_line(input int r, input int ly);
      logic [31:0] w = rec_at(r);
      int y = int'(w[17:8]);
      return w[28] && (y <= ly) && (ly < y + size_of(r));
   endfunction

   function automatic int line_hits(input int ly);
      int n = 0;
      for (int r = 0; r < NREC; r++) if (bool_line(r, ly)) n++;
      return n;
   endfunction

   // The first LIST_DEPTH line hits in record order are kept; the earliest
   // one covering the column wins.
   function automatic logic [11:0] model_pix(input int ly, input int px, input bit vid);
      int used = 0;
      if (!vid) return 12'h000;
      for (int r = 0; r < NREC; r++) begin
         if (bool_line(r, ly) && used < LIST_DEPTH) begin
            logic [31:0] w = rec_at(r);
            int x = int'(w[27:18]);
            used++;
            if (x <= px && px < x + size_of(r)) return color_of(r);
         end
      end
      return 12'h000;
   endfunction

   task automatic clear_recs();
      tank = '0;
      oppo = '0;
      for (int k = 0; k < NB; k++) bullets[k] = '0;
   endtask

   task automatic do_line(input int py);
      int cnt = 0;
      pixel_y  = 10'(py);
      video_on = 1'b0;
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
      while (scan_busy && cnt < 100) begin
         cnt++;
         tick();
      end
      check("scan_busy_len", cnt, 18);
      line_y_m = (py == 524) ? 0 : py + 1;
      if (line_hits(line_y_m) > LIST_DEPTH) exp_ovf = 1'b1;
      check("overflow_flag", overflow, exp_ovf);
   endtask

   task automatic pix(input string name, input int px, input bit vid, input logic [11:0] exp);
      pixel_x  = 10'(px);
      video_on = vid;
      tick();
      check(name, rgb, exp);
   endtask

   task automatic add_vec(input string name, input int px, input bit vid, input logic [11:0] e);
      vec_t v;
      v.name = name; v.px = px; v.vid = vid; v.exp_rgb = e;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b0; video_on = 1'b0; line_end = 1'b0;
      pixel_x = '0; pixel_y = '0;
      clear_recs();
      tick(); tick();
      check("reset_rgb", rgb, 12'h000);
      check("reset_busy", scan_busy, 1'b0);
      check("reset_ovf", overflow, 1'b0);
      reset = 1'b1;
      pix("no_list_after_reset", 100, 1'b1, 12'h000);

      // Tank span, table-driven
      tank = mk_rec(1'b1, 100, 50);
      do_line(49);
      pixel_y = 10'd50;
      add_vec("tank_left_out", 99, 1'b1, 12'h000);
      add_vec("tank_left_edge", 100, 1'b1, 12'h0F0);
      add_vec("tank_mid", 107, 1'b1, 12'h0F0);
      add_vec("tank_right_edge", 115, 1'b1, 12'h0F0);
      add_vec("tank_right_out", 116, 1'b1, 12'h000);
      add_vec("tank_video_off", 107, 1'b0, 12'h000);
      add_vec("tank_col0", 0, 1'b1, 12'h000);
      foreach (vecs[i]) pix(vecs[i].name, vecs[i].px, vecs[i].vid, vecs[i].exp_rgb);

      // Inactive record
      tank = mk_rec(1'b0, 100, 50);
      do_line(49);
      pix("inactive_100", 100, 1'b1, 12'h000);
      pix("inactive_107", 107, 1'b1, 12'h000);

      // No horizontal wrap at column 1023
      tank = mk_rec(1'b1, 1020, 50);
      do_line(49);
      for (int px = 0; px < 12; px++) pix("nowrap_low_cols", px, 1'b1, 12'h000);
      pix("nowrap_1020", 1020, 1'b1, 12'h0F0);
      pix("nowrap_1023", 1023, 1'b1, 12'h0F0);

      // Frame wrap: last line of frame scans line 0
      tank = mk_rec(1'b1, 100, 0);
      do_line(524);
      pix("vwrap_line0", 100, 1'b1, 12'h0F0);

      // Priority and bullet span
      tank = mk_rec(1'b1, 100, 50);
      bullets[0] = mk_rec(1'b1, 100, 50);
      oppo = mk_rec(1'b1, 300, 45);
      do_line(49);
      pix("prio_tank_over_bullet", 101, 1'b1, 12'h0F0);
      pix("prio_oppo", 300, 1'b1, 12'hF00);
      tank = '0;
      oppo = '0;
      bullets[0] = mk_rec(1'b1, 200, 50);
      do_line(49);
      pix("bullet_199", 199, 1'b1, 12'h000);
      for (int px = 200; px < 204; px++) pix("bullet_span", px, 1'b1, 12'hFF0);
      pix("bullet_204", 204, 1'b1, 12'h000);

      // Overflow: ten bullets on the line, tanks elsewhere
      clear_recs();
      tank = mk_rec(1'b1, 100, 300);
      oppo = mk_rec(1'b1, 200, 300);
      for (int k = 0; k < 10; k++) bullets[k] = mk_rec(1'b1, 20*k, 50);
      do_line(49);
      check("ovf_set", overflow, 1'b1);
      for (int k = 0; k < 10; k++)
         pix("ovf_bullet", 20*k + 1, 1'b1, (k < 8) ? 12'hFF0 : 12'h000);
      do_line(200);
      check("ovf_sticky", overflow, 1'b1);

      // Restart: second line_end five cycles after the first
      clear_recs();
      tank = mk_rec(1'b1, 100, 50);
      bullets[0] = mk_rec(1'b1, 200, 80);
      pixel_y = 10'd49;
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
      check("restart_busy_first", scan_busy, 1'b1);
      repeat (4) tick();
      do_line(79);
      pix("restart_old_line_gone", 100, 1'b1, 12'h000);
      pix("restart_new_line", 200, 1'b1, 12'hFF0);

      // Asynchronous reset in the middle of a scan
      do_line(49);
      pixel_y = 10'd49;
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
      repeat (5) tick();
      check("midscan_busy", scan_busy, 1'b1);
      check("midscan_ovf_before", overflow, exp_ovf);
      #2 reset = 1'b0;
      #1;
      check("async_rst_busy", scan_busy, 1'b0);
      check("async_rst_ovf", overflow, 1'b0);
      check("async_rst_rgb", rgb, 12'h000);
      exp_ovf = 1'b0;
      tick();
      reset = 1'b1;
      pixel_y = 10'd50;
      pix("post_rst_nodraw_100", 100, 1'b1, 12'h000);
      pix("post_rst_nodraw_200", 200, 1'b1, 12'h000);

      // Randomized lines against the model
      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < NREC; r++) begin
            logic [31:0] w = $urandom;
            w[28]    = ($urandom_range(0, 3) != 0);
            w[27:18] = 10'($urandom_range(0, 1023));
            w[17:8]  = 10'($urandom_range(0, 70));
            if (r == 0) tank = w;
            else if (r == 1) oppo = w;
            else bullets[r-2] = w;
         end
         do_line((it % 10 == 0) ? 524 : int'($urandom_range(0, 69)));
         for (int s = 0; s < 12; s++) begin
            int px;
            bit vid = ($urandom_range(0, 7) != 0);
            if (s % 2 == 0) begin
               px = int'($urandom_range(0, 1023));
            end else begin
               logic [31:0] w = rec_at(int'($urandom_range(0, NREC-1)));
               px = (int'(w[27:18]) + int'($urandom_range(0, 20)) - 2) & 1023;
            end
            pix("rand_pix", px, vid, model_pix(line_y_m, px, vid));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
